// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 1024x768 @ 65 MHz raster constants shared with the pixel generators
package vga_timing_pkg;
  localparam int VGA_H_ACTIVE = 1024;
  localparam int VGA_H_FP = 24;
  localparam int VGA_H_SYNCP = 136;
  localparam int VGA_H_BP = 160;
  localparam int VGA_V_ACTIVE = 768;
  localparam int VGA_V_FP = 3;
  localparam int VGA_V_SYNCP = 6;
  localparam int VGA_V_BP = 29;
  localparam int VGA_H_TOTAL = VGA_H_FP + VGA_H_SYNCP + VGA_H_BP + VGA_H_ACTIVE;
  localparam int VGA_V_TOTAL = VGA_V_FP + VGA_V_SYNCP + VGA_V_BP + VGA_V_ACTIVE;
  localparam logic VGA_HS_POL = 1'b0;
  localparam logic VGA_VS_POL = 1'b0;
endpackage

// File: rtl/sig_delay.sv
// sig_delay: W-bit shift register of depth D with async reset to RST_VAL (D=0 is a wire)
module sig_delay #(
  parameter int W = 1,
  parameter int D = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  if (D == 0) begin : g_wire
    assign q = d;
  end else begin : g_sr
    logic [W-1:0] sr [D];
    // shift one stage per clock; reset flushes every stage to the inactive value
    always_ff @(posedge clk or posedge rst)
      if (rst) sr <= '{default: RST_VAL};
      else begin
        sr[0] <= d;
        for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
      end
    assign q = sr[D-1];
  end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters, sync/active flags and pipeline-aligned sync/DE outputs
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP = VGA_H_FP,
  parameter int H_SYNCP = VGA_H_SYNCP,
  parameter int H_BP = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP = VGA_V_FP,
  parameter int V_SYNCP = VGA_V_SYNCP,
  parameter int V_BP = VGA_V_BP,
  parameter logic HS_POL = VGA_HS_POL,
  parameter logic VS_POL = VGA_VS_POL,
  parameter int PIPE_DLY = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [11:0] h_counter,
  output logic [11:0] v_counter,
  output logic        video_active,
  output logic        line_start,
  output logic        frame_start,
  output logic        hs_o,
  output logic        vs_o,
  output logic        de_o
);
  localparam logic [11:0] H_TOTAL = 12'(H_FP + H_SYNCP + H_BP + H_ACTIVE);
  localparam logic [11:0] V_TOTAL = 12'(V_FP + V_SYNCP + V_BP + V_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_FP);
  localparam logic [11:0] HS_END = 12'(H_FP + H_SYNCP);
  localparam logic [11:0] HA_START = 12'(H_FP + H_SYNCP + H_BP);
  localparam logic [11:0] VS_START = 12'(V_FP);
  localparam logic [11:0] VS_END = 12'(V_FP + V_SYNCP);
  localparam logic [11:0] VA_START = 12'(V_FP + V_SYNCP + V_BP);
  logic [11:0] h_nxt, v_nxt;
  logic h_wrap, hs_nxt, vs_nxt, va_nxt, hs_r, vs_r;
  logic [2:0] dly_q;
  // next raster position and the flags describing it, so registered flags match the registered counters
  always_comb begin
    h_wrap = h_counter == H_TOTAL - 12'd1;
    h_nxt = h_wrap ? 12'd0 : h_counter + 12'd1;
    v_nxt = !h_wrap ? v_counter : (v_counter == V_TOTAL - 12'd1) ? 12'd0 : v_counter + 12'd1;
    hs_nxt = (h_nxt >= HS_START && h_nxt < HS_END) ? HS_POL : ~HS_POL;
    vs_nxt = (v_nxt >= VS_START && v_nxt < VS_END) ? VS_POL : ~VS_POL;
    va_nxt = h_nxt >= HA_START && v_nxt >= VA_START;
  end
  // counters and undelayed flags; reset presents (0,0) with every flag inactive
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      h_counter <= '0;
      v_counter <= '0;
      video_active <= 1'b0;
      line_start <= 1'b0;
      frame_start <= 1'b0;
      hs_r <= ~HS_POL;
      vs_r <= ~VS_POL;
    end else begin
      h_counter <= h_nxt;
      v_counter <= v_nxt;
      video_active <= va_nxt;
      line_start <= h_nxt == 12'd0;
      frame_start <= h_nxt == 12'd0 && v_nxt == 12'd0;
      hs_r <= hs_nxt;
      vs_r <= vs_nxt;
    end
  sig_delay #(.W(3), .D(PIPE_DLY), .RST_VAL({~HS_POL, ~VS_POL, 1'b0})) u_dly (
    .clk(clk),
    .rst(rst),
    .d({hs_r, vs_r, video_active}),
    .q(dly_q)
  );
  assign {hs_o, vs_o, de_o} = dly_q;
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the 1024x768 @ 65 MHz VGA path. It produces the free-running `h_counter`/`v_counter` pair and the `video_active` qualifier that downstream pixel generators consume. It also produces the HSYNC/VSYNC pins. Because pixel generators register RGB one cycle after decoding the counters, the block also emits sync and data-enable copies delayed by a configurable pipeline depth, so they stay aligned with the RGB reaching the DAC/encoder.

## Interface
Parameters:
- `H_ACTIVE`, 1024: active pixels per line
- `H_FP`, 24: horizontal front porch, pixels
- `H_SYNCP`, 136: horizontal sync width, pixels
- `H_BP`, 160: horizontal back porch, pixels
- `V_ACTIVE`, 768: active lines per frame
- `V_FP`, 3: vertical front porch, lines
- `V_SYNCP`, 6: vertical sync width, lines
- `V_BP`, 29: vertical back porch, lines
- `HS_POL`, 1'b0: hsync asserted level
- `VS_POL`, 1'b0: vsync asserted level
- `PIPE_DLY`, 1: delay in clocks applied to `hs_o`/`vs_o`/`de_o`; legal range 0..7

Ports:
- `clk`, in, 1: pixel clock
- `rst`, in, 1: reset; asynchronous, active-high
- `h_counter`, out, 12: horizontal position in the full line, 0..H_TOTAL-1
- `v_counter`, out, 12: vertical position in the full frame, 0..V_TOTAL-1
- `video_active`, out, 1: high when the counters lie in the active region
- `line_start`, out, 1: 1-cycle pulse when `h_counter`==0
- `frame_start`, out, 1: 1-cycle pulse when `h_counter`==0 and `v_counter`==0
- `hs_o`, out, 1: hsync, delayed PIPE_DLY clocks
- `vs_o`, out, 1: vsync, delayed PIPE_DLY clocks
- `de_o`, out, 1: `video_active` delayed PIPE_DLY clocks

## Operation
- Totals: H_TOTAL = H_FP+H_SYNCP+H_BP+H_ACTIVE = 1344; V_TOTAL = V_FP+V_SYNCP+V_BP+V_ACTIVE = 806.
- Segment order on both axes is front porch, sync, back porch, active, all starting at counter 0.
- `h_counter` increments every clock and wraps H_TOTAL-1 -> 0.
- `v_counter` increments only on the clock where `h_counter` wraps, and itself wraps V_TOTAL-1 -> 0 on that same clock.
- Undelayed hsync is asserted (=HS_POL) iff H_FP <= h_counter < H_FP+H_SYNCP, i.e. h = 24..159.
- Undelayed vsync is asserted (=VS_POL) iff V_FP <= v_counter < V_FP+V_SYNCP, i.e. v = 3..8. It is line-based and changes on the h-wrap clock.
- `video_active` = (h_counter >= H_FP+H_SYNCP+H_BP) && (v_counter >= V_FP+V_SYNCP+V_BP). This covers h 320..1343 and v 38..805.
- All outputs are registers. Flags are computed from next-state counter values, so in every cycle each flag is exactly the stated function of the `h_counter`/`v_counter` values presented in that same cycle.
- Delay line: `hs_o`/`vs_o`/`de_o` equal the undelayed signals from PIPE_DLY clocks earlier. PIPE_DLY=0 makes them identical to the undelayed values.
- Counter arithmetic is 12-bit unsigned. Comparisons use 12-bit constants, and totals must be less than 4096.

## Timing
- Reset (async assert, sync release) sets:
  - counters to 0
  - `video_active`, `de_o`, `line_start`, `frame_start` to 0
  - `hs_o` to ~HS_POL and `vs_o` to ~VS_POL (inactive)
  - every delay-line stage to these inactive values
- First clock edge after reset release: counters go to h=1, v=0.
- The (0,0) point is presented during reset. `frame_start` is not asserted for it; the first `frame_start` occurs after a full frame.
- Reset mid-frame: all outputs go to reset values immediately, with no partial sync pulse stretched. The delay line is flushed to inactive.
- Simultaneous h-wrap and v-wrap: both counters go to 0 on the same clock, and `frame_start` and `line_start` assert together in that cycle.
- Frame period is exactly 1344*806 = 1,083,264 clocks. `frame_start` has exactly this spacing.

## Structure
- Shared package `vga_timing_pkg`: the 1024x768 timing constants, derived H_TOTAL/V_TOTAL, and the polarity defaults. Pixel generators import the same constants.
- Sub-module `sig_delay`: parameterised width/depth shift register with async reset and a parameterised reset value, instantiated once for the 3-bit {hs, vs, de} bundle.

## Test plan
- Reset: hold `rst` for 5 clocks -> counters 0/0, `hs_o`=`vs_o`=1, `de_o`=0, all pulses 0. Release -> next cycle h=1, v=0.
- Line wrap: run to h=1343, v=0 -> next cycle h=0, v=1, and `line_start`=1 for exactly that cycle.
- Frame wrap: run to h=1343, v=805 -> next cycle h=0, v=0, with `frame_start`=`line_start`=1. Spacing between `frame_start` pulses is 1,083,264 clocks.
- Sync windows:
  - undelayed hsync is low for h 24..159 (136 clocks/line)
  - vsync is low for v 3..8 (6 lines)
  - with PIPE_DLY=1, `hs_o` falls at the cycle where h=25
- Active region: `video_active` first rises at h=320, v=38 and stays high 1024 clocks per line for 768 lines. With PIPE_DLY=3, `de_o` rises at h=323.
- Reset mid-frame at h=500, v=400 -> all outputs return to reset values asynchronously, and counting restarts from (0,0).
